// File: rtl/spi_slave_cfg.sv
// SPI slave, all four modes, any word width, either bit order.
// Separate TX/RX shifters; word handshake via request/first/din/dout.
//
// Ports:
//   clk_i, reset_i     local clock, synchronous active-high reset
//   select_i, mclk_i   chip select (active high) and SPI clock from master
//   mosi_i / miso_o    serial data in / out; miso_oe_o is the pad enable
//   din_i              next word to send, latched the clk after request_o
//   dout_o             last complete word received
//   request_o, first_o word request pulse; first_o marks transfer start
//   abort_o            select lost with a partial word received
module spi_slave_cfg #(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 1,
  parameter int CPHA      = 1,
  parameter int LSB_FIRST = 0,
  parameter int SYNC      = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             select_i,
  input  logic             mclk_i,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             request_o,
  output logic             first_o,
  output logic             abort_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic POL = (CPOL != 0);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic sel_s, mclk_s, mosi_s;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] sel_q, mclk_q, mosi_q;
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          sel_q  <= 2'b00;
          mclk_q <= {2{POL}};
          mosi_q <= 2'b00;
        end else begin
          sel_q  <= {sel_q[0], select_i};
          mclk_q <= {mclk_q[0], mclk_i};
          mosi_q <= {mosi_q[0], mosi_i};
        end
      end
      assign sel_s  = sel_q[1];
      assign mclk_s = mclk_q[1];
      assign mosi_s = mosi_q[1];
    end else begin : g_raw
      assign sel_s  = select_i;
      assign mclk_s = mclk_i;
      assign mosi_s = mosi_i;
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic             req_q, req_d;
  logic             first_q, first_d;
  logic             abort_q, abort_d;
  logic             mclk_prev_q;

  logic lead, trail, sample_e, shift_e;
  logic [WIDTH-1:0] rx_next;

  assign lead  = (mclk_prev_q == POL) && (mclk_s != POL);
  assign trail = (mclk_prev_q != POL) && (mclk_s == POL);
  assign sample_e = (CPHA == 0) ? lead : trail;
  assign shift_e  = (CPHA == 0) ? trail : lead;

  assign rx_next = (LSB_FIRST != 0) ? {mosi_s, rx_q[WIDTH-1:1]}
                                    : {rx_q[WIDTH-2:0], mosi_s};

  function automatic logic head(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      dout_q      <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      req_q       <= 1'b0;
      first_q     <= 1'b0;
      abort_q     <= 1'b0;
      mclk_prev_q <= POL;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dout_q      <= dout_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      req_q       <= req_d;
      first_q     <= first_d;
      abort_q     <= abort_d;
      mclk_prev_q <= mclk_s;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    oe_d    = sel_s;
    req_d   = 1'b0;
    first_d = 1'b0;
    abort_d = 1'b0;
    if (!sel_s) begin
      state_d = IDLE;
      abort_d = (state_q == SHIFT) && (cnt_q != '0);
    end else begin
      unique case (state_q)
        IDLE: begin
          req_d   = 1'b1;
          first_d = 1'b1;
          state_d = LOAD;
        end
        LOAD: begin
          cnt_d   = '0;
          state_d = SHIFT;
          // CPHA=0 must present the first bit before the first lead edge
          if (CPHA == 0) begin
            miso_d = head(din_i);
            tx_d   = adv(din_i);
          end else begin
            tx_d = din_i;
          end
        end
        SHIFT: begin
          // CPHA=0: a shift edge at count 0 is the previous word's trail
          if (shift_e && ((CPHA != 0) || (cnt_q != '0))) begin
            miso_d = head(tx_q);
            tx_d   = adv(tx_q);
          end
          if (sample_e) begin
            rx_d = rx_next;
            if (cnt_q == LAST) begin
              dout_d  = rx_next;
              req_d   = 1'b1;
              cnt_d   = '0;
              state_d = LOAD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign miso_o    = miso_q;
  assign miso_oe_o = oe_q;
  assign dout_o    = dout_q;
  assign request_o = req_q;
  assign first_o   = first_q;
  assign abort_o   = abort_q;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench for spi_slave_cfg: five instances cover the four
// SPI modes, 16-bit words, LSB-first and the unsynchronised variant.
module tb_spi_slave_cfg;

  localparam int H = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sel;
  logic        mclk;
  logic        mosi;
  logic [31:0] din;

  logic [4:0]  miso, oe, req, frst, abrt;
  logic [7:0]  d0, d2, d3, d4;
  logic [15:0] d1;
  logic [31:0] dw [5];

  logic [2:0]  cur;
  int          vec = 0;
  int          miscmp = 0;

  always #5 clk = ~clk;

  // k=0: mode3 W8
  spi_slave_cfg #(.WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .SYNC(1)) u_m3 (
    .clk_i(clk), .reset_i(reset), .select_i(sel[0]), .mclk_i(mclk),
    .mosi_i(mosi), .miso_o(miso[0]), .miso_oe_o(oe[0]), .din_i(din[7:0]),
    .dout_o(d0), .request_o(req[0]), .first_o(frst[0]), .abort_o(abrt[0]));

  // k=1: mode0 W16
  spi_slave_cfg #(.WIDTH(16), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC(1)) u_m0w16 (
    .clk_i(clk), .reset_i(reset), .select_i(sel[1]), .mclk_i(mclk),
    .mosi_i(mosi), .miso_o(miso[1]), .miso_oe_o(oe[1]), .din_i(din[15:0]),
    .dout_o(d1), .request_o(req[1]), .first_o(frst[1]), .abort_o(abrt[1]));

  // k=2: mode1 W8 LSB first
  spi_slave_cfg #(.WIDTH(8), .CPOL(0), .CPHA(1), .LSB_FIRST(1), .SYNC(1)) u_m1lsb (
    .clk_i(clk), .reset_i(reset), .select_i(sel[2]), .mclk_i(mclk),
    .mosi_i(mosi), .miso_o(miso[2]), .miso_oe_o(oe[2]), .din_i(din[7:0]),
    .dout_o(d2), .request_o(req[2]), .first_o(frst[2]), .abort_o(abrt[2]));

  // k=3: mode2 W8
  spi_slave_cfg #(.WIDTH(8), .CPOL(1), .CPHA(0), .LSB_FIRST(0), .SYNC(1)) u_m2 (
    .clk_i(clk), .reset_i(reset), .select_i(sel[3]), .mclk_i(mclk),
    .mosi_i(mosi), .miso_o(miso[3]), .miso_oe_o(oe[3]), .din_i(din[7:0]),
    .dout_o(d3), .request_o(req[3]), .first_o(frst[3]), .abort_o(abrt[3]));

  // k=4: mode0 W8 without synchronisers
  spi_slave_cfg #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC(0)) u_m0ns (
    .clk_i(clk), .reset_i(reset), .select_i(sel[4]), .mclk_i(mclk),
    .mosi_i(mosi), .miso_o(miso[4]), .miso_oe_o(oe[4]), .din_i(din[7:0]),
    .dout_o(d4), .request_o(req[4]), .first_o(frst[4]), .abort_o(abrt[4]));

  assign dw[0] = {24'h0, d0};
  assign dw[1] = {16'h0, d1};
  assign dw[2] = {24'h0, d2};
  assign dw[3] = {24'h0, d3};
  assign dw[4] = {24'h0, d4};

  // request log: first flag and dout seen with every request pulse
  logic [31:0] rd [5][16];
  logic        rf [5][16];
  int          rn [5] = '{default: 0};
  int          an [5] = '{default: 0};

  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (req[k] === 1'b1) begin
        if (rn[k] < 16) begin
          rf[k][rn[k]] = frst[k];
          rd[k][rn[k]] = dw[k];
        end
        rn[k] = rn[k] + 1;
      end
      if (abrt[k] === 1'b1) an[k] = an[k] + 1;
    end
  end

  function automatic logic [31:0] rdv(input int k, input int i);
    if (i >= 0 && i < 16) return rd[k][i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic rfv(input int k, input int i);
    if (i >= 0 && i < 16) return rf[k][i];
    return 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // master side of one word; drop ends select right after the last
  // sample edge (CPHA=0 only)
  task automatic xfer(input int cpol, input int cpha, input int lsb,
                      input int w, input logic [31:0] tx, input bit drop,
                      output logic [31:0] got);
    int idx;
    got = '0;
    for (int i = 0; i < w; i++) begin
      idx = (lsb != 0) ? i : w - 1 - i;
      if (cpha == 0) begin
        mosi = tx[idx];
        #H;
        mclk = (cpol == 0);
        got[idx] = miso[cur];
        if (drop && i == w - 1) begin
          #10;
          sel[cur] = 1'b0;
          #(H - 10);
        end else begin
          #H;
        end
        mclk = (cpol != 0);
      end else begin
        mclk = (cpol == 0);
        mosi = tx[idx];
        #H;
        mclk = (cpol != 0);
        got[idx] = miso[cur];
        #H;
      end
    end
  endtask

  initial begin
    logic [31:0] g, g2;
    int b, ab;
    reset = 1'b1;
    sel   = '0;
    mclk  = 1'b1;
    mosi  = 1'b0;
    din   = '0;
    cur   = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_miso",  {27'h0, miso}, 32'h0);
    chk("rst_oe",    {27'h0, oe},   32'h0);
    chk("rst_req",   {27'h0, req},  32'h0);
    chk("rst_first", {27'h0, frst}, 32'h0);
    chk("rst_abort", {27'h0, abrt}, 32'h0);
    chk("rst_dout0", dw[0], 32'h0);
    chk("rst_dout1", dw[1], 32'h0);
    reset = 1'b0;
    #100;

    // mode3 W8: receive 3C, send A5
    cur = 3'd0; mclk = 1'b1; din = 32'hA5;
    b = rn[0]; ab = an[0];
    sel[0] = 1'b1;
    #100;
    chk("m3_oe_on", {31'h0, oe[0]}, 32'h1);
    xfer(1, 1, 0, 8, 32'h3C, 1'b0, g);
    #50;
    sel[0] = 1'b0;
    #100;
    chk("m3_miso",  g, 32'hA5);
    chk("m3_nreq",  rn[0] - b, 32'd2);
    chk("m3_first", {31'h0, rfv(0, b)}, 32'h1);
    chk("m3_wfirst", {31'h0, rfv(0, b + 1)}, 32'h0);
    chk("m3_rdout", rdv(0, b + 1), 32'h3C);
    chk("m3_dout",  dw[0], 32'h3C);
    chk("m3_abort", an[0] - ab, 32'd0);
    chk("m3_oe_off", {31'h0, oe[0]}, 32'h0);

    // mode0 W16: back-to-back words
    cur = 3'd1; mclk = 1'b0; din = 32'hCAFE;
    b = rn[1]; ab = an[1];
    sel[1] = 1'b1;
    #100;
    din = 32'h0F0F;
    xfer(0, 0, 0, 16, 32'h1234, 1'b0, g);
    xfer(0, 0, 0, 16, 32'hBEEF, 1'b0, g2);
    #100;
    sel[1] = 1'b0;
    #100;
    chk("m0_miso1", g,  32'hCAFE);
    chk("m0_miso2", g2, 32'h0F0F);
    chk("m0_nreq",  rn[1] - b, 32'd3);
    chk("m0_first", {31'h0, rfv(1, b)}, 32'h1);
    chk("m0_dout1", rdv(1, b + 1), 32'h1234);
    chk("m0_dout2", rdv(1, b + 2), 32'hBEEF);
    chk("m0_abort", an[1] - ab, 32'd0);

    // mode1 W8 LSB first
    cur = 3'd2; mclk = 1'b0; din = 32'h80;
    b = rn[2];
    sel[2] = 1'b1;
    #100;
    xfer(0, 1, 1, 8, 32'h01, 1'b0, g);
    #50;
    sel[2] = 1'b0;
    #100;
    chk("m1_bit0",  {31'h0, g[0]}, 32'h0);
    chk("m1_bit7",  {31'h0, g[7]}, 32'h1);
    chk("m1_miso",  g, 32'h80);
    chk("m1_dout",  dw[2], 32'h01);
    chk("m1_nreq",  rn[2] - b, 32'd2);

    // mode2 W8: full word 55, then select lost after 3 bits
    cur = 3'd3; mclk = 1'b1; din = 32'h00;
    ab = an[3];
    sel[3] = 1'b1;
    #100;
    xfer(1, 0, 0, 8, 32'h55, 1'b0, g);
    #50;
    sel[3] = 1'b0;
    #100;
    chk("m2_dout",   dw[3], 32'h55);
    chk("m2_noabrt", an[3] - ab, 32'd0);
    b = rn[3];
    sel[3] = 1'b1;
    #100;
    xfer(1, 0, 0, 3, 32'h2, 1'b0, g);
    #50;
    sel[3] = 1'b0;
    #100;
    chk("m2_abort",  an[3] - ab, 32'd1);
    chk("m2_keep",   dw[3], 32'h55);
    chk("m2_oe",     {31'h0, oe[3]}, 32'h0);
    chk("m2_nreq",   rn[3] - b, 32'd1);

    // mode3: reset mid-word, then a fresh transfer
    cur = 3'd0; mclk = 1'b1; din = 32'hFF;
    sel[0] = 1'b1;
    #100;
    xfer(1, 1, 0, 4, 32'h0, 1'b0, g);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rm_miso",  {31'h0, miso[0]}, 32'h0);
    chk("rm_oe",    {31'h0, oe[0]},   32'h0);
    chk("rm_dout",  dw[0], 32'h0);
    chk("rm_req",   {30'h0, req[0], frst[0]}, 32'h0);
    chk("rm_abort", {31'h0, abrt[0]}, 32'h0);
    sel[0] = 1'b0;
    reset = 1'b0;
    #100;
    b = rn[0]; ab = an[0];
    din = 32'h96;
    sel[0] = 1'b1;
    #100;
    xfer(1, 1, 0, 8, 32'hC3, 1'b0, g);
    #50;
    sel[0] = 1'b0;
    #100;
    chk("rm_first", {31'h0, rfv(0, b)}, 32'h1);
    chk("rm_rdout", rdv(0, b + 1), 32'hC3);
    chk("rm_dout2", dw[0], 32'hC3);
    chk("rm_miso2", g, 32'h96);
    chk("rm_noab",  an[0] - ab, 32'd0);

    // mode0 unsynchronised: select drops right after the 8th sample
    cur = 3'd4; mclk = 1'b0; din = 32'h3A;
    b = rn[4]; ab = an[4];
    sel[4] = 1'b1;
    #100;
    xfer(0, 0, 0, 8, 32'h5C, 1'b1, g);
    #100;
    chk("ns_miso",  g, 32'h3A);
    chk("ns_nreq",  rn[4] - b, 32'd2);
    chk("ns_rdout", rdv(4, b + 1), 32'h5C);
    chk("ns_dout",  dw[4], 32'h5C);
    chk("ns_noab",  an[4] - ab, 32'd0);
    chk("ns_oe",    {31'h0, oe[4]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
